// File: rtl/mini_src_control_unit.sv
// Hardwired sequencer for CPU_Datapath: fetch in T0-T2, per-opcode execute in T3-T7.
// Strobes are a combinational decode of the step/wait registers, IR[31:27] and CON_FF_Out.
module mini_src_control_unit #(
    parameter int         MEM_WAIT = 0,
    parameter logic [4:0] ALU_ADD  = 5'b00001,
    parameter logic [4:0] ALU_SUB  = 5'b00010,
    parameter logic [4:0] ALU_AND  = 5'b00011,
    parameter logic [4:0] ALU_OR   = 5'b00100
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] IR,
    input  logic        CON_FF_Out,
    input  logic        stop,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        MDRread,
    output logic        wren,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        ZLOout,
    output logic        HIout,
    output logic        LOout,
    output logic        InPortout,
    output logic        OPin,
    output logic        Cout,
    output logic        BAout,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        CON_FF_In,
    output logic [4:0]  ALUSelection,
    output logic        run,
    output logic [3:0]  step
);

    // step | meaning
    // T0-T2 | instruction fetch (T1 holds for MEM_WAIT extra cycles)
    // T3-T7 | execute steps for the decoded opcode
    // RESET | clr asserted, everything idle
    // HALT  | stopped until clr
    typedef enum logic [3:0] {
        ST_T0 = 4'd0, ST_T1 = 4'd1, ST_T2 = 4'd2, ST_T3 = 4'd3,
        ST_T4 = 4'd4, ST_T5 = 4'd5, ST_T6 = 4'd6, ST_T7 = 4'd7,
        ST_RESET = 4'd8, ST_HALT = 4'd9
    } step_e;

    localparam logic [2:0] LP_WAIT = 3'(MEM_WAIT);

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b01010;
    localparam logic [4:0] OP_OR   = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_HALT = 5'b11011;

    step_e      r_step;
    logic [2:0] r_waitcnt;
    logic       r_halted;

    logic [4:0] w_op;
    logic       w_unused_ir;
    logic       w_is_mem;
    logic       w_is_alur;
    logic       w_is_alui;
    logic [4:0] w_alu_code;
    logic       w_wait_step;
    logic       w_wait_first;
    logic       w_wait_last;
    logic       w_last_step;

    assign w_op         = IR[31:27];
    assign w_unused_ir  = ^IR[26:0];
    assign w_is_mem     = (w_op == OP_LD) || (w_op == OP_LDI) || (w_op == OP_ST);
    assign w_is_alur    = (w_op == OP_ADD) || (w_op == OP_SUB) || (w_op == OP_AND) || (w_op == OP_OR);
    assign w_is_alui    = (w_op == OP_ADDI) || (w_op == OP_ANDI) || (w_op == OP_ORI);
    assign w_wait_step  = (r_step == ST_T1) || ((r_step == ST_T6) && (w_op == OP_LD));
    assign w_wait_first = (r_waitcnt == LP_WAIT);
    assign w_wait_last  = (r_waitcnt == 3'd0);

    assign run  = ~r_step[3] & ~r_halted;
    assign step = r_step;

    always_comb begin
        w_alu_code = 5'd0;
        case (w_op)
            OP_ADD, OP_ADDI: w_alu_code = ALU_ADD;
            OP_SUB:          w_alu_code = ALU_SUB;
            OP_AND, OP_ANDI: w_alu_code = ALU_AND;
            OP_OR, OP_ORI:   w_alu_code = ALU_OR;
            default:         w_alu_code = 5'd0;
        endcase
    end

    always_comb begin
        w_last_step = 1'b0;
        case (r_step)
            ST_T3:   w_last_step = !(w_is_mem || w_is_alur || w_is_alui || (w_op == OP_BR));
            ST_T5:   w_last_step = (w_op == OP_LDI) || w_is_alur || w_is_alui;
            ST_T6:   w_last_step = (w_op == OP_BR);
            ST_T7:   w_last_step = 1'b1;
            default: w_last_step = 1'b0;
        endcase
    end

    // Wait steps count down from MEM_WAIT; every step advance reloads the counter.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_step    <= ST_RESET;
            r_waitcnt <= 3'd0;
            r_halted  <= 1'b0;
        end else begin
            case (r_step)
                ST_RESET: r_step <= ST_T0;
                ST_HALT:  r_step <= ST_HALT;
                default: begin
                    if (w_wait_step && !w_wait_last) begin
                        r_waitcnt <= r_waitcnt - 3'd1;
                    end else if (w_last_step) begin
                        if ((w_op == OP_HALT) || stop) begin
                            r_step   <= ST_HALT;
                            r_halted <= 1'b1;
                        end else begin
                            r_step <= ST_T0;
                        end
                    end else begin
                        r_step    <= step_e'(r_step + 4'd1);
                        r_waitcnt <= LP_WAIT;
                    end
                end
            endcase
        end
    end

    always_comb begin
        PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0;
        MDRin = 1'b0; MDRout = 1'b0; MDRread = 1'b0; wren = 1'b0;
        IRin = 1'b0; Yin = 1'b0; Zin = 1'b0; ZLOout = 1'b0;
        HIout = 1'b0; LOout = 1'b0; InPortout = 1'b0; OPin = 1'b0;
        Cout = 1'b0; BAout = 1'b0; Gra = 1'b0; Grb = 1'b0;
        Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; CON_FF_In = 1'b0;
        ALUSelection = 5'd0;
        case (r_step)
            ST_T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
            end
            ST_T1: begin
                ZLOout  = 1'b1;
                MDRread = 1'b1;
                PCin    = w_wait_first;
                MDRin   = w_wait_last;
            end
            ST_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
            end
            ST_T3: begin
                if (w_is_mem) begin
                    Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
                end else if (w_is_alur || w_is_alui) begin
                    Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end else begin
                    case (w_op)
                        OP_BR:   begin Gra = 1'b1; Rout = 1'b1; CON_FF_In = 1'b1; end
                        OP_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                        OP_IN:   begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        OP_OUT:  begin Gra = 1'b1; Rout = 1'b1; OPin = 1'b1; end
                        OP_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        OP_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        default: ;
                    endcase
                end
            end
            ST_T4: begin
                if (w_is_mem) begin
                    Cout = 1'b1; Zin = 1'b1; ALUSelection = ALU_ADD;
                end else if (w_is_alur) begin
                    Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; ALUSelection = w_alu_code;
                end else if (w_is_alui) begin
                    Cout = 1'b1; Zin = 1'b1; ALUSelection = w_alu_code;
                end else if (w_op == OP_BR) begin
                    PCout = 1'b1; Yin = 1'b1;
                end
            end
            ST_T5: begin
                if ((w_op == OP_LD) || (w_op == OP_ST)) begin
                    ZLOout = 1'b1; MARin = 1'b1;
                end else if ((w_op == OP_LDI) || w_is_alur || w_is_alui) begin
                    ZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (w_op == OP_BR) begin
                    Cout = 1'b1; Zin = 1'b1; ALUSelection = ALU_ADD;
                end
            end
            ST_T6: begin
                if (w_op == OP_LD) begin
                    MDRread = 1'b1;
                    MDRin   = w_wait_last;
                end else if (w_op == OP_ST) begin
                    Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
                end else if ((w_op == OP_BR) && CON_FF_Out) begin
                    ZLOout = 1'b1; PCin = 1'b1;
                end
            end
            ST_T7: begin
                if (w_op == OP_LD) begin
                    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (w_op == OP_ST) begin
                    wren = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mini_src_control_unit.sv
// Bench for mini_src_control_unit: three instances (MEM_WAIT 0/2/3) checked every cycle
// against an instruction-timeline model, plus literal checks of cycle counts and halt/reset behaviour.
module tb_mini_src_control_unit;

    localparam int MWS[3] = '{0, 2, 3};
    localparam int M_RESET = 0, M_RUN = 1, M_HALT = 2;

    localparam logic [23:0] PCOUT = 24'd1 << 0,  PCIN = 24'd1 << 1,  INCPC = 24'd1 << 2,  MARIN = 24'd1 << 3;
    localparam logic [23:0] MDRIN = 24'd1 << 4,  MDROUT = 24'd1 << 5, MDRREAD = 24'd1 << 6, WREN = 24'd1 << 7;
    localparam logic [23:0] IRIN = 24'd1 << 8,   YIN = 24'd1 << 9,   ZIN = 24'd1 << 10,   ZLOOUT = 24'd1 << 11;
    localparam logic [23:0] HIOUT = 24'd1 << 12, LOOUT = 24'd1 << 13, INPOUT = 24'd1 << 14, OPIN = 24'd1 << 15;
    localparam logic [23:0] COUT = 24'd1 << 16,  BAOUT = 24'd1 << 17, GRA = 24'd1 << 18,   GRB = 24'd1 << 19;
    localparam logic [23:0] GRC = 24'd1 << 20,   RIN = 24'd1 << 21,  ROUT = 24'd1 << 22,  CONIN = 24'd1 << 23;

    logic        clk = 1'b0;
    logic [31:0] ir = 32'd0;
    logic        con = 1'b0;
    logic        stop = 1'b0;
    logic        clr_req = 1'b1;
    int          cur = 0;
    logic        started = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          m_mode[3];
    int          m_k[3];
    logic [4:0]  ops_t[0:17];

    wire [2:0]  clr_v;
    wire [23:0] stb_w[3];
    wire [4:0]  alu_w[3];
    wire        run_w[3];
    wire [3:0]  step_w[3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign clr_v[g] = clr_req | (cur != g);
        mini_src_control_unit #(.MEM_WAIT(MWS[g])) dut (
            .clk(clk), .clr(clr_v[g]), .IR(ir), .CON_FF_Out(con), .stop(stop),
            .PCout(stb_w[g][0]), .PCin(stb_w[g][1]), .IncPC(stb_w[g][2]), .MARin(stb_w[g][3]),
            .MDRin(stb_w[g][4]), .MDRout(stb_w[g][5]), .MDRread(stb_w[g][6]), .wren(stb_w[g][7]),
            .IRin(stb_w[g][8]), .Yin(stb_w[g][9]), .Zin(stb_w[g][10]), .ZLOout(stb_w[g][11]),
            .HIout(stb_w[g][12]), .LOout(stb_w[g][13]), .InPortout(stb_w[g][14]), .OPin(stb_w[g][15]),
            .Cout(stb_w[g][16]), .BAout(stb_w[g][17]), .Gra(stb_w[g][18]), .Grb(stb_w[g][19]),
            .Grc(stb_w[g][20]), .Rin(stb_w[g][21]), .Rout(stb_w[g][22]), .CON_FF_In(stb_w[g][23]),
            .ALUSelection(alu_w[g]), .run(run_w[g]), .step(step_w[g])
        );
    end

    function automatic logic [4:0] alu_of(input logic [4:0] op);
        case (op)
            5'b00011, 5'b01100: return 5'b00001;
            5'b00100:           return 5'b00010;
            5'b01010, 5'b01101: return 5'b00011;
            5'b01011, 5'b01110: return 5'b00100;
            default:            return 5'b00000;
        endcase
    endfunction

    function automatic int instr_len(input logic [4:0] op, input int mw);
        int ex;
        case (op)
            5'b00000: ex = 5 + mw;
            5'b00010: ex = 5;
            5'b10011: ex = 4;
            default:  ex = (alu_of(op) != 5'd0 || op == 5'b00001) ? 3 : 1;
        endcase
        return 3 + mw + ex;
    endfunction

    // Expected {step, run, ALUSelection, strobes} for cycle k of the instruction timeline.
    function automatic logic [33:0] model_out(input int mode, input int k, input logic [4:0] op,
                                              input logic cf, input int mw);
        logic [23:0] s;
        logic [4:0]  a;
        int          st, e;
        logic        is_alu, is_imm;
        s = '0; a = '0; st = 0;
        if (mode == M_RESET) return {4'd8, 30'd0};
        if (mode == M_HALT)  return {4'd9, 30'd0};
        is_alu = (alu_of(op) != 5'd0);
        is_imm = (op == 5'b01100) || (op == 5'b01101) || (op == 5'b01110);
        if (k == 0) begin
            s = PCOUT | MARIN | INCPC | ZIN;
        end else if (k <= 1 + mw) begin
            st = 1; s = ZLOOUT | MDRREAD;
            if (k == 1) s |= PCIN;
            if (k == 1 + mw) s |= MDRIN;
        end else if (k == 2 + mw) begin
            st = 2; s = MDROUT | IRIN;
        end else begin
            e = k - (3 + mw);
            st = 3 + e;
            if (op == 5'b00000 && e >= 3) begin
                if (e <= 3 + mw) begin
                    st = 6; s = MDRREAD;
                    if (e == 3 + mw) s |= MDRIN;
                end else begin
                    st = 7; s = MDROUT | GRA | RIN;
                end
            end else if (op == 5'b00000 || op == 5'b00001 || op == 5'b00010) begin
                case (e)
                    0: s = GRB | BAOUT | YIN;
                    1: begin s = COUT | ZIN; a = 5'b00001; end
                    2: s = (op == 5'b00001) ? (ZLOOUT | GRA | RIN) : (ZLOOUT | MARIN);
                    3: s = GRA | ROUT | MDRIN;
                    default: s = WREN;
                endcase
            end else if (is_alu) begin
                case (e)
                    0: s = GRB | ROUT | YIN;
                    1: begin s = (is_imm ? COUT : (GRC | ROUT)) | ZIN; a = alu_of(op); end
                    default: s = ZLOOUT | GRA | RIN;
                endcase
            end else if (op == 5'b10011) begin
                case (e)
                    0: s = GRA | ROUT | CONIN;
                    1: s = PCOUT | YIN;
                    2: begin s = COUT | ZIN; a = 5'b00001; end
                    default: s = cf ? (ZLOOUT | PCIN) : 24'd0;
                endcase
            end else begin
                case (op)
                    5'b10100: s = GRA | ROUT | PCIN;
                    5'b10110: s = INPOUT | GRA | RIN;
                    5'b10111: s = GRA | ROUT | OPIN;
                    5'b11000: s = HIOUT | GRA | RIN;
                    5'b11001: s = LOOUT | GRA | RIN;
                    default:  s = 24'd0;
                endcase
            end
        end
        return {4'(st), 1'b1, a, s};
    endfunction

    initial begin
        for (int i = 0; i < 3; i++) begin m_mode[i] = M_RESET; m_k[i] = 0; end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (clr_v[i]) begin
                m_mode[i] = M_RESET; m_k[i] = 0;
            end else if (m_mode[i] == M_RESET) begin
                m_mode[i] = M_RUN; m_k[i] = 0;
            end else if (m_mode[i] == M_RUN) begin
                if (m_k[i] + 1 >= instr_len(ir[31:27], MWS[i])) begin
                    if (ir[31:27] == 5'b11011 || stop) m_mode[i] = M_HALT;
                    m_k[i] = 0;
                end else begin
                    m_k[i] = m_k[i] + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 3; i++) begin
                logic [33:0] act, exp;
                act = {step_w[i], run_w[i], alu_w[i], stb_w[i]};
                exp = model_out(m_mode[i], m_k[i], ir[31:27], con, MWS[i]);
                checks++;
                if (act !== exp) begin
                    errors++;
                    $display("FAIL cycle_out inst=%0d t=%0t act=%h exp=%h", i, $time, act, exp);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++; errors++;
        $display("FAIL timeout %s act=expired exp=event", name);
    endtask

    task automatic wait_t0();
        int b = 0;
        while (!(m_mode[cur] == M_RUN && m_k[cur] == 0)) begin
            clr_req = (m_mode[cur] == M_HALT);
            @(posedge clk); #1;
            if (++b > 60) begin timeout("wait_t0"); break; end
        end
        clr_req = 1'b0;
    endtask

    task automatic wait_k(input int kk);
        int b = 0;
        while (!(m_mode[cur] == M_RUN && m_k[cur] == kk)) begin
            @(posedge clk); #1;
            if (++b > 60) begin timeout("wait_k"); break; end
        end
    endtask

    task automatic do_instr(input logic [31:0] ir_v, input logic con_v, input logic stop_v,
                            output int len, output int n_mdrin, output int n_pcin);
        int b = 0;
        len = 0; n_mdrin = 0; n_pcin = 0;
        wait_t0();
        ir = ir_v; con = con_v; stop = stop_v; len = 1;
        forever begin
            @(posedge clk); #1;
            if (m_mode[cur] != M_RUN || m_k[cur] == 0) break;
            len++;
            n_mdrin += int'(stb_w[cur][4]);
            n_pcin  += int'(stb_w[cur][1]);
            if (++b > 60) begin timeout("do_instr"); break; end
        end
        stop = 1'b0;
    endtask

    function automatic logic [31:0] mk_ir(input logic [4:0] op);
        return {op, 27'($urandom)};
    endfunction

    task automatic random_run(input int n);
        int len, nm, np;
        logic [4:0] op;
        for (int j = 0; j < n; j++) begin
            int r = $urandom_range(0, 18);
            op = (r == 18) ? 5'($urandom) : ops_t[r];
            do_instr(mk_ir(op), 1'($urandom), ($urandom_range(0, 9) == 0), len, nm, np);
        end
    endtask

    initial begin
        int len, nm, np;
        ops_t = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b01010, 5'b01011, 5'b01100, 5'b01101,
                  5'b01110, 5'b10011, 5'b10100, 5'b10110, 5'b10111, 5'b11000, 5'b11001, 5'b11010, 5'b11011};
        @(posedge clk); #1;
        started = 1'b1;
        @(posedge clk); #1;
        chk("reset_step", 32'(step_w[0]), 32'd8);
        chk("reset_strobes", 32'(stb_w[0]), 32'd0);

        cur = 0;
        do_instr(32'h02800075, 1'b0, 1'b0, len, nm, np);
        chk("ld_mw0_len", len, 8);
        chk("ld_mw0_mdrin", nm, 2);
        chk("ld_mw0_pcin", np, 1);
        do_instr(32'h19918000, 1'b0, 1'b0, len, nm, np);
        chk("add_len", len, 6);
        do_instr({5'b10011, 27'h0123456}, 1'b0, 1'b0, len, nm, np);
        chk("br_con0_len", len, 7);
        chk("br_con0_pcin", np, 1);
        do_instr({5'b10011, 27'h0123456}, 1'b1, 1'b0, len, nm, np);
        chk("br_con1_pcin", np, 2);
        do_instr({5'b11011, 27'd0}, 1'b0, 1'b0, len, nm, np);
        chk("halt_len", len, 4);
        chk("halt_step", 32'(step_w[0]), 32'd9);
        chk("halt_run", 32'(run_w[0]), 32'd0);
        do_instr({5'b11010, 27'd0}, 1'b0, 1'b0, len, nm, np);
        chk("nop_after_clr_len", len, 4);

        wait_t0();
        ir = 32'h19918000; con = 1'b0;
        wait_k(4);
        stop = 1'b1;
        begin
            int b = 0;
            while (m_mode[cur] == M_RUN) begin
                @(posedge clk); #1;
                if (++b > 20) begin timeout("stop_add"); break; end
            end
        end
        stop = 1'b0;
        chk("stop_add_step", 32'(step_w[0]), 32'd9);
        chk("stop_add_run", 32'(run_w[0]), 32'd0);
        random_run(60);

        cur = 2;
        do_instr(32'h02800075, 1'b0, 1'b0, len, nm, np);
        chk("ld_mw3_len", len, 14);
        chk("ld_mw3_mdrin", nm, 2);
        random_run(60);

        cur = 1;
        wait_t0();
        ir = 32'h02800075;
        wait_k(9);
        chk("mid_t6_step", 32'(step_w[1]), 32'd6);
        clr_req = 1'b1;
        @(posedge clk); #1;
        chk("clr_step", 32'(step_w[1]), 32'd8);
        chk("clr_strobes", 32'(stb_w[1]), 32'd0);
        @(posedge clk); #1;
        clr_req = 1'b0;
        @(posedge clk); #1;
        chk("resume_step", 32'(step_w[1]), 32'd0);
        chk("resume_strobes", 32'(stb_w[1]), 32'(PCOUT | MARIN | INCPC | ZIN));
        random_run(60);

        @(negedge clk);
        started = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1, "global timeout");
    end

endmodule
